ret_addr_stack: RTL and testbench
=================================

// Module: ret_addr_stack
// PURPOSE
//  Parametrised return-address stack for the basic CPU control path; successor of the
//  fixed 16x10 stack. A call pushes PC+1. A return pops. An interrupt return yields the
//  interrupted PC. Adds occupancy count, full/empty, sticky overflow/underflow flags
//  and same-cycle push+pop (replace top). Sits between the PC mux and the control unit.
// PARAMETERS
//  AW     10                  address (entry) width in bits
//  DEPTH  16                  number of stored entries, >=2
//  CW     $clog2(DEPTH+1)     width of count (derived, do not override)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high
//  push       in   1   call: store pc_in+1 on top
//  pop        in   1   return: discard top entry
//  intr_ret   in   1   top_out presents stored value minus 1 (interrupt return)
//  err_clr    in   1   clear sticky error flags
//  pc_in      in   AW  current PC for push
//  top_out    out  AW  top-of-stack value (combinational)
//  count      out  CW  number of valid entries, 0..DEPTH
//  empty      out  1   count==0
//  full       out  1   count==DEPTH
//  overflow   out  1   sticky: push attempted while full
//  underflow  out  1   sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset (async): count=0, overflow=0, underflow=0. Hence empty=1, full=0, top_out=0.
//    Storage array is not reset. Reset mid-operation discards all entries immediately.
//  - Storage: mem[0..DEPTH-1]. The top entry is mem[count-1].
//  - Actions per rising edge, decided on {push,pop}:
//    00: hold.
//    10, not full: mem[count] <= pc_in+1; count <= count+1.
//    10, full: no write, count holds, overflow <= 1.
//    01, not empty: count <= count-1. mem is untouched.
//    01, empty: count holds, underflow <= 1.
//    11, not empty: replace the top. mem[count-1] <= pc_in+1. count holds. No flag.
//    11, empty: behaves as push (count becomes 1). underflow <= 1.
//  - Arithmetic: pc_in+1 and stored-1 are modulo 2^AW. 2^AW-1 stores as 0.
//    Stored 0 with intr_ret presents 2^AW-1.
//  - top_out = empty ? 0 : (intr_ret ? mem[count-1]-1 : mem[count-1]).
//    Zero-cycle read latency. A push is visible on top_out the cycle after the edge.
//  - err_clr clears both flags at the edge. If an error occurs in the same cycle, set wins.
//  - count, empty and full update only at clock edges. empty and full are decoded
//    from the registered count.
//  - intr_ret affects only top_out, never state.
// TESTING
//  1. Reset, then idle -> count=0, empty=1, full=0, top_out=0, overflow=0, underflow=0.
//  2. push pc_in=5 -> top_out=6, count=1. Assert intr_ret -> top_out=5. Then pop -> empty=1.
//  3. Push 16x (DEPTH=16), pc_in=0..15 -> full=1, top_out=16. A 17th push (pc_in=99)
//     -> overflow=1, count=16, top_out=16.
//  4. Pop on empty -> underflow=1, count=0. Assert err_clr while popping empty ->
//     underflow stays 1. err_clr alone -> 0.
//  5. Push 10, push 20, then push+pop with pc_in=40 -> count=2, top_out=41.
//     pop -> top_out=11.
//  6. AW=10, push pc_in=1023 -> top_out=0. With intr_ret -> 1023. Assert reset mid-burst
//     -> count=0 asynchronously, before the next edge.

Source files
------------

// File: rtl/ret_addr_stack_if.sv
// Control-path bus between the control unit (master) and the return-address stack (slave).
// Carries call/return requests, the PC to push, and the stack status and top value.
interface ret_addr_stack_if #(
  parameter int AW    = 10,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          push;
  logic          pop;
  logic          intr_ret;
  logic          err_clr;
  logic [AW-1:0] pc_in;
  logic [AW-1:0] top_out;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, pop, intr_ret, err_clr, pc_in,
    input  top_out, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, intr_ret, err_clr, pc_in,
    output top_out, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/ret_addr_stack.sv
// Parametrised return-address stack: call pushes PC+1, return pops, push+pop replaces
// the top. Tracks occupancy and keeps sticky overflow/underflow flags.
module ret_addr_stack #(
  parameter int AW    = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  ret_addr_stack_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [AW-1:0] wr_data;
  logic [CW-1:0] top_cnt;
  logic [IW-1:0] top_idx;
  logic [AW-1:0] top_val;
  logic [AW-1:0] top_out;
  logic          empty;
  logic          full;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign top_cnt = count_q - CW'(1);
  assign top_idx = top_cnt[IW-1:0];
  assign wr_data = bus.pc_in + AW'(1);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    count_d     = count_q;
    overflow_d  = overflow_q  & ~bus.err_clr;
    underflow_d = underflow_q & ~bus.err_clr;
    wr_en       = 1'b0;
    wr_idx      = count_q[IW-1:0];

    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty) underflow_d = 1'b1;
        else       count_d     = top_cnt;
      end
      2'b11: begin
        wr_en = 1'b1;
        if (empty) begin
          // Pop of nothing still flags, but the call half proceeds as a plain push.
          wr_idx      = '0;
          count_d     = CW'(1);
          underflow_d = 1'b1;
        end else begin
          wr_idx = top_idx;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage has no reset; entries at or above count are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  always_comb begin
    top_val = mem_q[top_idx];
    top_out = '0;
    if (!empty) top_out = bus.intr_ret ? (top_val - AW'(1)) : top_val;
  end

  assign bus.top_out   = top_out;
  assign bus.count     = count_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed bench for ret_addr_stack (AW=10, DEPTH=16) with hand-computed expectations.
module tb_ret_addr_stack;
  localparam int AW    = 10;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  ret_addr_stack_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  ret_addr_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;
    bus.err_clr  = 1'b0;
    bus.intr_ret = 1'b0;
  endtask

  task automatic do_push(input logic [AW-1:0] pc);
    bus.pc_in = pc;
    bus.push  = 1'b1;
    tick();
  endtask

  task automatic do_pop();
    bus.pop = 1'b1;
    tick();
  endtask

  initial begin
    reset        = 1'b1;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;
    bus.intr_ret = 1'b0;
    bus.err_clr  = 1'b0;
    bus.pc_in    = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Reset / idle state
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full",  bus.full, 0);
    check("rst_top",   bus.top_out, 0);
    check("rst_ovf",   bus.overflow, 0);
    check("rst_unf",   bus.underflow, 0);

    // Single push, interrupt-return view, pop
    do_push(10'd5);
    check("push5_top",   bus.top_out, 6);
    check("push5_count", bus.count, 1);
    bus.intr_ret = 1'b1;
    #1 check("push5_intr", bus.top_out, 5);
    check("intr_no_state", bus.count, 1);
    bus.intr_ret = 1'b0;
    do_pop();
    check("pop1_empty", bus.empty, 1);
    check("pop1_top",   bus.top_out, 0);

    // Fill to DEPTH, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      do_push(AW'(i));
      if (i == 0) check("fill_first_top", bus.top_out, 1);
    end
    check("fill_full",  bus.full, 1);
    check("fill_count", bus.count, 16);
    check("fill_top",   bus.top_out, 16);
    check("fill_ovf0",  bus.overflow, 0);
    do_push(10'd99);
    check("ovf_flag",  bus.overflow, 1);
    check("ovf_count", bus.count, 16);
    check("ovf_top",   bus.top_out, 16);
    bus.err_clr = 1'b1;
    tick();
    check("ovf_clr", bus.overflow, 0);
    do_pop();
    check("drain_top",   bus.top_out, 15);
    check("drain_count", bus.count, 15);
    for (int i = 0; i < DEPTH - 1; i++) do_pop();
    check("drain_empty", bus.empty, 1);
    check("drain_unf",   bus.underflow, 0);

    // Underflow, set-wins-over-clear, clear
    do_pop();
    check("unf_flag",  bus.underflow, 1);
    check("unf_count", bus.count, 0);
    bus.err_clr = 1'b1;
    bus.pop     = 1'b1;
    tick();
    check("unf_set_wins", bus.underflow, 1);
    bus.err_clr = 1'b1;
    tick();
    check("unf_clr", bus.underflow, 0);

    // Push+pop on empty acts as push and flags underflow
    bus.pc_in = 10'd7;
    bus.push  = 1'b1;
    bus.pop   = 1'b1;
    tick();
    check("pp_empty_count", bus.count, 1);
    check("pp_empty_top",   bus.top_out, 8);
    check("pp_empty_unf",   bus.underflow, 1);
    bus.pop     = 1'b1;
    bus.err_clr = 1'b1;
    tick();
    check("pp_clr_count", bus.count, 0);
    check("pp_clr_unf",   bus.underflow, 0);

    // Replace top
    do_push(10'd10);
    do_push(10'd20);
    bus.pc_in = 10'd40;
    bus.push  = 1'b1;
    bus.pop   = 1'b1;
    tick();
    check("repl_count", bus.count, 2);
    check("repl_top",   bus.top_out, 41);
    check("repl_unf",   bus.underflow, 0);
    do_pop();
    check("repl_pop_top", bus.top_out, 11);
    do_pop();
    check("repl_pop_empty", bus.empty, 1);

    // Address wrap, then async reset mid-burst
    do_push(10'd1023);
    check("wrap_top", bus.top_out, 0);
    bus.intr_ret = 1'b1;
    #1 check("wrap_intr", bus.top_out, 1023);
    bus.intr_ret = 1'b0;
    do_push(10'd100);
    do_push(10'd200);
    check("burst_count", bus.count, 3);
    bus.push  = 1'b1;
    bus.pc_in = 10'd300;
    #2 reset = 1'b1;
    #1;
    check("async_count", bus.count, 0);
    check("async_empty", bus.empty, 1);
    check("async_top",   bus.top_out, 0);
    bus.push = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("post_rst_count", bus.count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
